// File: rtl/mem_access_stage_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
// Holds access-size encodings, FSM state type and the captured-op payload.
package mem_access_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned BE_W  = 4;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Everything needed to keep the bus stable and finish the op while waiting for ack
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   wdata;
        logic [BE_W-1:0]   be;
        size_e             size;
        logic              uns;
        logic              memtoreg;
        logic              regwrite;
        logic [XLEN-1:0]   alu_result;
        logic [REG_W-1:0]  dest;
    } mem_op_t;

    // Reserved size encoding behaves as a word access
    function automatic size_e norm_size(input logic [1:0] s);
        case (s)
            2'b01:   return SZ_HALF;
            2'b10:   return SZ_BYTE;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic [BE_W-1:0] byte_en(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            SZ_BYTE: return 4'b0001 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] replicate(input size_e sz, input logic [XLEN-1:0] d);
        case (sz)
            SZ_HALF: return {2{d[15:0]}};
            SZ_BYTE: return {4{d[7:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_HALF: return lo[0];
            SZ_BYTE: return 1'b0;
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Memory-side request/response bus of the memory-access stage.
interface mem_access_stage_if;
    import mem_access_stage_pkg::*;

    logic            Mem_req;
    logic            Mem_we;
    logic [XLEN-1:0] Mem_addr;
    logic [XLEN-1:0] Mem_wdata;
    logic [BE_W-1:0] Mem_be;
    logic            Mem_ack;
    logic [XLEN-1:0] Mem_rdata;

    modport master (
        output Mem_req, Mem_we, Mem_addr, Mem_wdata, Mem_be,
        input  Mem_ack, Mem_rdata
    );

    modport slave (
        input  Mem_req, Mem_we, Mem_addr, Mem_wdata, Mem_be,
        output Mem_ack, Mem_rdata
    );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// Extracts the addressed byte/half lane of a read word and sign/zero-extends it.
module load_align
    import mem_access_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  size_e           size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{addr_lo, 3'b000} +: 8];
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data   = rdata;
        case (size)
            SZ_BYTE: data = is_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: data = is_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack bus, stalls
// upstream while waiting, and registers results toward the MEM/WB boundary.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Valid_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic [XLEN-1:0]   ALUResult_in,
    input  logic [XLEN-1:0]   WriteData_in,
    input  logic [REG_W-1:0]  DestReg_in,
    input  logic [1:0]        Size_in,
    input  logic              Unsigned_in,
    input  logic              Flush_in,
    mem_access_stage_if.master mem,
    output logic              Valid_out,
    output logic              MemtoReg_out,
    output logic              RegWrite_out,
    output logic [XLEN-1:0]   ALUResult_out,
    output logic [XLEN-1:0]   ReadData_out,
    output logic [REG_W-1:0]  DestReg_out,
    output logic              Misalign_out,
    output logic              Stall_out
);

    state_e             state_q, state_d;
    mem_op_t            op_q, op_d;
    logic               flush_q, flush_d;
    logic               valid_q, valid_d;
    logic               memtoreg_q, memtoreg_d;
    logic               regwrite_q, regwrite_d;
    logic [XLEN-1:0]    alu_q, alu_d;
    logic [XLEN-1:0]    rdata_q, rdata_d;
    logic [REG_W-1:0]   dest_q, dest_d;
    logic               misalign_q, misalign_d;

    size_e              in_size;
    logic               in_mem, in_mis;
    mem_op_t            in_op, cur_op;
    logic               in_wait, idle_accept, issue_c, busy_c, done_c, kill_c;
    logic [XLEN-1:0]    load_data_c;

    // Decode the incoming EX/MEM op
    assign in_size = norm_size(Size_in);
    assign in_mem  = MemRead_in | MemWrite_in;
    assign in_mis  = in_mem & misaligned(in_size, ALUResult_in[1:0]);

    always_comb begin
        in_op            = '0;
        in_op.we         = MemWrite_in;
        in_op.wdata      = replicate(in_size, WriteData_in);
        in_op.be         = byte_en(in_size, ALUResult_in[1:0]);
        in_op.size       = in_size;
        in_op.uns        = Unsigned_in;
        in_op.memtoreg   = MemtoReg_in;
        in_op.regwrite   = RegWrite_in;
        in_op.alu_result = ALUResult_in;
        in_op.dest       = DestReg_in;
    end

    // Reset gates the bus so nothing is requested while Rst is held low
    assign in_wait     = (state_q == ST_WAIT);
    assign idle_accept = Rst & ~in_wait & Valid_in & ~Flush_in;
    assign issue_c     = idle_accept & in_mem & ~in_mis;
    assign busy_c      = Rst & (issue_c | in_wait);
    assign done_c      = busy_c & mem.Mem_ack;
    assign kill_c      = in_wait & (flush_q | Flush_in);
    assign cur_op      = in_wait ? op_q : in_op;

    load_align u_load_align (
        .rdata       (mem.Mem_rdata),
        .addr_lo     (cur_op.alu_result[1:0]),
        .size        (cur_op.size),
        .is_unsigned (cur_op.uns),
        .data        (load_data_c)
    );

    // FSM state register
    always_ff @(posedge Clk) begin
        if (!Rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue_c && !mem.Mem_ack) state_d = ST_WAIT;
            ST_WAIT: if (mem.Mem_ack)             state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: bus drive and upstream stall
    always_comb begin
        mem.Mem_req   = busy_c;
        mem.Mem_we    = busy_c & cur_op.we;
        mem.Mem_addr  = busy_c ? {cur_op.alu_result[XLEN-1:2], 2'b00} : '0;
        mem.Mem_wdata = busy_c ? cur_op.wdata : '0;
        mem.Mem_be    = busy_c ? cur_op.be : '0;
        Stall_out     = busy_c & ~mem.Mem_ack;
    end

    // Captured op and MEM/WB result next values; non-completing cycles emit bubbles
    always_comb begin
        op_d       = op_q;
        flush_d    = flush_q;
        valid_d    = 1'b0;
        regwrite_d = 1'b0;
        misalign_d = 1'b0;
        memtoreg_d = memtoreg_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        dest_d     = dest_q;

        if (issue_c && !mem.Mem_ack) begin
            op_d    = in_op;
            flush_d = 1'b0;
        end
        if (in_wait && Flush_in) flush_d = 1'b1;

        if (done_c) begin
            valid_d    = ~kill_c;
            regwrite_d = cur_op.regwrite & ~cur_op.we & ~kill_c;
            memtoreg_d = cur_op.memtoreg;
            alu_d      = cur_op.alu_result;
            dest_d     = cur_op.dest;
            rdata_d    = cur_op.we ? '0 : load_data_c;
            flush_d    = 1'b0;
        end else if (idle_accept && !issue_c) begin
            valid_d    = 1'b1;
            regwrite_d = RegWrite_in & ~in_mis;
            misalign_d = in_mis;
            memtoreg_d = MemtoReg_in;
            alu_d      = ALUResult_in;
            dest_d     = DestReg_in;
            rdata_d    = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            op_q       <= '0;
            flush_q    <= 1'b0;
            valid_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            alu_q      <= '0;
            rdata_q    <= '0;
            dest_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            flush_q    <= flush_d;
            valid_q    <= valid_d;
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
            dest_q     <= dest_d;
            misalign_q <= misalign_d;
        end
    end

    assign Valid_out     = valid_q;
    assign MemtoReg_out  = memtoreg_q;
    assign RegWrite_out  = regwrite_q;
    assign ALUResult_out = alu_q;
    assign ReadData_out  = rdata_q;
    assign DestReg_out   = dest_q;
    assign Misalign_out  = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

    logic        Clk, Rst;
    logic        Valid_in, MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in;
    logic [31:0] ALUResult_in, WriteData_in;
    logic [4:0]  DestReg_in;
    logic [1:0]  Size_in;
    logic        Unsigned_in, Flush_in;
    logic        Valid_out, MemtoReg_out, RegWrite_out, Misalign_out, Stall_out;
    logic [31:0] ALUResult_out, ReadData_out;
    logic [4:0]  DestReg_out;

    int n_total = 0;
    int n_pass  = 0;
    int stall_cnt;

    mem_access_stage_if mif();

    mem_access_stage dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Valid_in     (Valid_in),
        .MemRead_in   (MemRead_in),
        .MemWrite_in  (MemWrite_in),
        .MemtoReg_in  (MemtoReg_in),
        .RegWrite_in  (RegWrite_in),
        .ALUResult_in (ALUResult_in),
        .WriteData_in (WriteData_in),
        .DestReg_in   (DestReg_in),
        .Size_in      (Size_in),
        .Unsigned_in  (Unsigned_in),
        .Flush_in     (Flush_in),
        .mem          (mif),
        .Valid_out    (Valid_out),
        .MemtoReg_out (MemtoReg_out),
        .RegWrite_out (RegWrite_out),
        .ALUResult_out(ALUResult_out),
        .ReadData_out (ReadData_out),
        .DestReg_out  (DestReg_out),
        .Misalign_out (Misalign_out),
        .Stall_out    (Stall_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                         input logic rw, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] dst, input logic [1:0] sz, input logic uns,
                         input logic fl);
        Valid_in = v; MemRead_in = rd; MemWrite_in = wr; MemtoReg_in = m2r;
        RegWrite_in = rw; ALUResult_in = alu; WriteData_in = wd; DestReg_in = dst;
        Size_in = sz; Unsigned_in = uns; Flush_in = fl;
    endtask

    task automatic idle_in;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        Rst = 1'b0;
        mif.Mem_ack = 1'b0;
        mif.Mem_rdata = 32'h0;
        // a memory op presented during reset must not reach the bus
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd3, 2'b00, 1'b0, 1'b0);
        tick; tick;
        chk("rst_req", 32'(mif.Mem_req), 32'h0);
        chk("rst_stall", 32'(Stall_out), 32'h0);
        chk("rst_valid", 32'(Valid_out), 32'h0);
        chk("rst_regwrite", 32'(RegWrite_out), 32'h0);
        chk("rst_misalign", 32'(Misalign_out), 32'h0);
        chk("rst_alu", ALUResult_out, 32'h0);
        idle_in;
        Rst = 1'b1;
        tick;

        // plain ALU op passes through in one cycle
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd5, 2'b00, 1'b0, 1'b0);
        #1;
        chk("alu_stall", 32'(Stall_out), 32'h0);
        chk("alu_req", 32'(mif.Mem_req), 32'h0);
        tick;
        idle_in;
        chk("alu_valid", 32'(Valid_out), 32'h1);
        chk("alu_regwrite", 32'(RegWrite_out), 32'h1);
        chk("alu_result", ALUResult_out, 32'h1234);
        chk("alu_dest", 32'(DestReg_out), 32'h5);
        chk("alu_rdata", ReadData_out, 32'h0);
        chk("alu_stall2", 32'(Stall_out), 32'h0);
        tick;
        chk("bubble_valid", 32'(Valid_out), 32'h0);
        chk("bubble_regwrite", 32'(RegWrite_out), 32'h0);
        chk("bubble_hold_alu", ALUResult_out, 32'h1234);

        // signed byte load at 0x103, ack after three wait cycles
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 5'd7, 2'b10, 1'b0, 1'b0);
        stall_cnt = 0;
        #1;
        chk("lb_req", 32'(mif.Mem_req), 32'h1);
        chk("lb_we", 32'(mif.Mem_we), 32'h0);
        chk("lb_addr", mif.Mem_addr, 32'h100);
        chk("lb_be", 32'(mif.Mem_be), 32'h8);
        if (Stall_out) stall_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick;
            #1;
            chk("lb_wait_req", 32'(mif.Mem_req), 32'h1);
            chk("lb_wait_addr", mif.Mem_addr, 32'h100);
            chk("lb_wait_be", 32'(mif.Mem_be), 32'h8);
            chk("lb_wait_valid", 32'(Valid_out), 32'h0);
            if (Stall_out) stall_cnt++;
        end
        mif.Mem_ack = 1'b1;
        mif.Mem_rdata = 32'h80FF_FFFF;
        #1;
        chk("lb_ack_stall", 32'(Stall_out), 32'h0);
        tick;
        mif.Mem_ack = 1'b0;
        idle_in;
        chk("lb_stall_cycles", 32'(stall_cnt), 32'd4);
        chk("lb_valid", 32'(Valid_out), 32'h1);
        chk("lb_regwrite", 32'(RegWrite_out), 32'h1);
        chk("lb_memtoreg", 32'(MemtoReg_out), 32'h1);
        chk("lb_rdata", ReadData_out, 32'hFFFF_FF80);
        chk("lb_dest", 32'(DestReg_out), 32'h7);
        #1;
        chk("lb_idle_req", 32'(mif.Mem_req), 32'h0);

        // unsigned half load, upper lane, ack in the issue cycle
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 32'h0, 5'd8, 2'b01, 1'b1, 1'b0);
        mif.Mem_ack = 1'b1;
        mif.Mem_rdata = 32'h8765_4321;
        #1;
        chk("lhu_be", 32'(mif.Mem_be), 32'hC);
        chk("lhu_addr", mif.Mem_addr, 32'h20);
        chk("lhu_stall", 32'(Stall_out), 32'h0);
        tick;
        chk("lhu_valid", 32'(Valid_out), 32'h1);
        chk("lhu_rdata", ReadData_out, 32'h0000_8765);

        // signed half load, lower lane, ack in the issue cycle
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 5'd9, 2'b01, 1'b0, 1'b0);
        mif.Mem_rdata = 32'h0000_9ABC;
        #1;
        chk("lh_be", 32'(mif.Mem_be), 32'h3);
        tick;
        chk("lh_rdata", ReadData_out, 32'hFFFF_9ABC);

        // reserved size acts as word; unsigned byte at lane 1
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h600, 32'h0, 5'd10, 2'b11, 1'b0, 1'b0);
        mif.Mem_rdata = 32'hCAFE_F00D;
        #1;
        chk("lw_rsvd_be", 32'(mif.Mem_be), 32'hF);
        tick;
        chk("lw_rsvd_rdata", ReadData_out, 32'hCAFE_F00D);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h601, 32'h0, 5'd10, 2'b10, 1'b1, 1'b0);
        mif.Mem_rdata = 32'h0000_F200;
        #1;
        chk("lbu_be", 32'(mif.Mem_be), 32'h2);
        tick;
        mif.Mem_ack = 1'b0;
        chk("lbu_rdata", ReadData_out, 32'h0000_00F2);

        // half store at 0x202 with both read and write set, ack after one wait cycle
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h202, 32'h0000_ABCD, 5'd0, 2'b01, 1'b0, 1'b0);
        #1;
        chk("sh_we", 32'(mif.Mem_we), 32'h1);
        chk("sh_be", 32'(mif.Mem_be), 32'hC);
        chk("sh_wdata", mif.Mem_wdata, 32'hABCD_ABCD);
        chk("sh_addr", mif.Mem_addr, 32'h200);
        tick;
        #1;
        chk("sh_wait_we", 32'(mif.Mem_we), 32'h1);
        chk("sh_wait_wdata", mif.Mem_wdata, 32'hABCD_ABCD);
        chk("sh_wait_stall", 32'(Stall_out), 32'h1);
        mif.Mem_ack = 1'b1;
        tick;
        mif.Mem_ack = 1'b0;
        idle_in;
        chk("sh_valid", 32'(Valid_out), 32'h1);
        chk("sh_regwrite", 32'(RegWrite_out), 32'h0);

        // byte store at lane 1, ack in the issue cycle
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h301, 32'h1234_56EF, 5'd0, 2'b10, 1'b0, 1'b0);
        mif.Mem_ack = 1'b1;
        #1;
        chk("sb_be", 32'(mif.Mem_be), 32'h2);
        chk("sb_wdata", mif.Mem_wdata, 32'hEFEF_EFEF);
        tick;
        mif.Mem_ack = 1'b0;

        // misaligned word load: no request, single-cycle flag
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h105, 32'h0, 5'd4, 2'b00, 1'b0, 1'b0);
        #1;
        chk("mis_w_req", 32'(mif.Mem_req), 32'h0);
        chk("mis_w_stall", 32'(Stall_out), 32'h0);
        tick;
        idle_in;
        chk("mis_w_flag", 32'(Misalign_out), 32'h1);
        chk("mis_w_valid", 32'(Valid_out), 32'h1);
        chk("mis_w_regwrite", 32'(RegWrite_out), 32'h0);
        chk("mis_w_alu", ALUResult_out, 32'h105);
        tick;
        chk("mis_w_clear", 32'(Misalign_out), 32'h0);

        // misaligned half store
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h203, 32'h55, 5'd0, 2'b01, 1'b0, 1'b0);
        #1;
        chk("mis_h_req", 32'(mif.Mem_req), 32'h0);
        tick;
        idle_in;
        chk("mis_h_flag", 32'(Misalign_out), 32'h1);

        // flush in IDLE discards the op
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h777, 32'h0, 5'd6, 2'b00, 1'b0, 1'b1);
        tick;
        idle_in;
        chk("flush_idle_valid", 32'(Valid_out), 32'h0);
        chk("flush_idle_regwrite", 32'(RegWrite_out), 32'h0);

        // flush on the second wait cycle of a word load
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd11, 2'b00, 1'b0, 1'b0);
        tick;
        tick;
        Flush_in = 1'b1;
        #1;
        chk("flw_req_flush", 32'(mif.Mem_req), 32'h1);
        tick;
        Flush_in = 1'b0;
        #1;
        chk("flw_req_held", 32'(mif.Mem_req), 32'h1);
        chk("flw_addr_held", mif.Mem_addr, 32'h400);
        mif.Mem_ack = 1'b1;
        mif.Mem_rdata = 32'h1122_3344;
        tick;
        mif.Mem_ack = 1'b0;
        idle_in;
        chk("flw_valid", 32'(Valid_out), 32'h0);
        chk("flw_regwrite", 32'(RegWrite_out), 32'h0);
        chk("flw_rdata", ReadData_out, 32'h1122_3344);

        // reset while waiting, then a stray ack
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd12, 2'b00, 1'b0, 1'b0);
        tick;
        Rst = 1'b0;
        tick;
        idle_in;
        Rst = 1'b1;
        mif.Mem_ack = 1'b1;
        mif.Mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rstw_req", 32'(mif.Mem_req), 32'h0);
        chk("rstw_stall", 32'(Stall_out), 32'h0);
        tick;
        mif.Mem_ack = 1'b0;
        chk("rstw_valid", 32'(Valid_out), 32'h0);
        chk("rstw_regwrite", 32'(RegWrite_out), 32'h0);
        chk("rstw_rdata", ReadData_out, 32'h0);
        tick;
        chk("rstw_valid2", 32'(Valid_out), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports: Clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: Rst  in  1  synchronous, active-low reset.
REQ-003 SHALL have EX/MEM-side inputs: Valid_in 1; MemRead_in 1; MemWrite_in 1; MemtoReg_in 1; RegWrite_in 1; ALUResult_in 32 (result/address); WriteData_in 32 (store data); DestReg_in 5; Size_in 2 (00 word, 01 half, 10 byte, 11 reserved=word); Unsigned_in 1 (zero-extend loads); Flush_in 1.
REQ-004 SHALL have memory-side ports: Mem_req out 1; Mem_we out 1; Mem_addr out 32 (word-aligned, [1:0]=0); Mem_wdata out 32 (lane-replicated); Mem_be out 4; Mem_ack in 1; Mem_rdata in 32.
REQ-005 SHALL have MEM/WB-side outputs: Valid_out 1; MemtoReg_out 1; RegWrite_out 1; ALUResult_out 32; ReadData_out 32; DestReg_out 5; Misalign_out 1; Stall_out 1 (upstream must hold inputs).

Function
REQ-006 SHALL implement FSM states IDLE and WAIT; reset state IDLE.
REQ-007 In IDLE with Valid_in=1, no memory op, no Flush_in: SHALL register inputs to outputs next edge, Valid_out=1, ReadData_out=0 (1-cycle latency).
REQ-008 In IDLE with Valid_in=1 and MemRead_in or MemWrite_in, aligned: SHALL assert Mem_req combinationally that cycle, Stall_out=1, capture op, go to WAIT unless Mem_ack=1 same cycle (then complete per REQ-010).
REQ-009 In WAIT: Mem_req, Mem_we, Mem_addr, Mem_wdata, Mem_be SHALL stay stable, Stall_out=1, until Mem_ack=1; no timeout.
REQ-010 On the Mem_ack cycle: SHALL register results next edge, return to IDLE, drop Stall_out same cycle as ack; load data SHALL come from Mem_rdata aligned per REQ-012.
REQ-011 Byte enables: word 1111; half 0011 at addr[1]=0, 1100 at addr[1]=1; byte one-hot by addr[1:0] (00->0001); store data replicated into all lanes.
REQ-012 Load alignment: selected lane shifted to bits [7:0]/[15:0]; sign-extended unless Unsigned_in=1.
REQ-013 Misalignment (half with addr[0]=1; word with addr[1:0]!=0): SHALL issue no Mem_req, pass through in 1 cycle with RegWrite_out=0, Valid_out=1, Misalign_out=1 for one cycle.
REQ-014 MemRead_in and MemWrite_in both 1: SHALL treat as store.
REQ-015 Flush_in in IDLE: SHALL discard the input, Valid_out=0, RegWrite_out=0 next edge.
REQ-016 Flush_in in WAIT: access SHALL run to Mem_ack (no abort); completed result SHALL be emitted with Valid_out=0, RegWrite_out=0.
REQ-017 Valid_out=0 cycles SHALL force RegWrite_out=0; other outputs don't-care but deterministic (hold).
REQ-018 Valid_in=0 in IDLE SHALL produce a bubble (Valid_out=0) next edge.

Reset
REQ-019 Rst=0 at a rising edge SHALL force IDLE and all outputs 0, incl. Mem_req, Stall_out, Valid_out, Misalign_out.
REQ-020 Reset during WAIT SHALL abandon the access; a later stray Mem_ack in IDLE SHALL be ignored.

Structure
REQ-021 Shared package SHALL hold Size encodings (SZ_WORD, SZ_HALF, SZ_BYTE) and FSM state typedef.
REQ-022 Load lane extraction/extension SHALL be a combinational sub-module load_align (inputs rdata, addr[1:0], size, unsigned; output 32-bit data).
REQ-023 Stage SHALL feed MEM_WB directly; no other combinational path from Mem_rdata to outputs.

Verification
REQ-024 ALU op ALUResult_in=0x1234, RegWrite_in=1, DestReg_in=5 -> next cycle ALUResult_out=0x1234, RegWrite_out=1, Stall_out never 1.
REQ-025 Signed byte load addr 0x103, Mem_rdata=0x80FF_FF_FF with ack after 3 cycles -> Mem_be=1000, Mem_addr=0x100, Stall_out 4 cycles, ReadData_out=0xFFFFFF80.
REQ-026 Half store addr 0x202 data 0x0000ABCD -> Mem_we=1, Mem_be=1100, Mem_wdata=0xABCDABCD, RegWrite_out=0.
REQ-027 Word load addr 0x105 -> no Mem_req, Misalign_out=1 one cycle, RegWrite_out=0.
REQ-028 Flush_in asserted second WAIT cycle of load -> Mem_req held to ack, then Valid_out=0, RegWrite_out=0.
REQ-029 Rst=0 in WAIT, then Mem_ack=1 after reset release -> stays IDLE, Valid_out=0, no spurious output.
